// File: rtl/mode_pkg.sv
// Shared constants for the LED animation mode selector:
// mode range/width, named modes, long-press FSM encoding.
package mode_pkg;

  localparam int NUM_MODES = 4;
  localparam int MODE_W    = 2;

  localparam logic [MODE_W-1:0] MODE_0 = 2'd0;
  localparam logic [MODE_W-1:0] MODE_1 = 2'd1;
  localparam logic [MODE_W-1:0] MODE_2 = 2'd2;
  localparam logic [MODE_W-1:0] MODE_3 = 2'd3;

  localparam logic [MODE_W-1:0] MODE_LAST =
    MODE_W'(NUM_MODES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> debounced level + 1-cycle rise pulse.
// Ports: clk, rst (async active-low), btn (raw), level, rise.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      level_q <= level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/mode_select.sv
// Button-driven animation mode register with wrap, long-press home.
// Ports: clk, rst (async active-low), btn_next, btn_prev, mode, mode_changed.
module mode_select
  import mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              btn_prev,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed
);

  localparam int HW =
    (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(LONG_PRESS_CYCLES - 1);

  logic nxt_lvl;
  logic nxt_rise;
  logic prv_lvl;
  logic prv_rise;
  logic unused_prv_lvl;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_next),
    .level(nxt_lvl),
    .rise (nxt_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_prev (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_prev),
    .level(prv_lvl),
    .rise (prv_rise)
  );

  // prev long press has no function
  assign unused_prv_lvl = prv_lvl;

  logic [1:0]        st;
  logic [HW-1:0]     hold;
  logic              long_ev;
  logic [MODE_W-1:0] mode_nxt;

  // fires once per hold; DONE blocks repeats until release
  assign long_ev = (st == HOLD) && nxt_lvl &&
                   (hold == HOLD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= IDLE;
      hold <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (nxt_rise) begin
            st   <= HOLD;
            hold <= '0;
          end
        end
        HOLD: begin
          if (!nxt_lvl) begin
            st <= IDLE;
          end else if (long_ev) begin
            st <= DONE;
          end else if (hold != HOLD_LAST) begin
            hold <= hold + 1'b1;
          end
        end
        DONE: begin
          if (!nxt_lvl) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_comb begin
    mode_nxt = mode;
    priority case (1'b1)
      long_ev:
        mode_nxt = MODE_0;
      nxt_rise && prv_rise:
        mode_nxt = mode;
      nxt_rise:
        mode_nxt = (mode == MODE_LAST) ? MODE_0
                                       : mode + 1'b1;
      prv_rise:
        mode_nxt = (mode == MODE_0) ? MODE_LAST
                                    : mode - 1'b1;
      default:
        mode_nxt = mode;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode         <= MODE_0;
      mode_changed <= 1'b0;
    end else begin
      mode         <= mode_nxt;
      mode_changed <= (mode_nxt != mode);
    end
  end

endmodule

// File: tb/tb_mode_select.sv
// Directed bench for mode_select with a cycle-stamped scoreboard.
// Small debounce/long-press counts keep runs short.
module tb_mode_select;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic [1:0] mode;
  logic       mode_changed;

  mode_select #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .mode        (mode),
    .mode_changed(mode_changed)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] m;
    logic       c;
    int         p;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  int    cyc = 0;
  int    pulses = 0;
  int    base = 0;
  int    vectors = 0;
  int    fails = 0;
  bit    done = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // cycle stamp k = checked at the negedge after posedge k
  initial forever begin
    @(negedge clk);
    if (mode_changed === 1'b1) pulses++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t  e;
      string t;
      e = q.pop_front();
      t = tq.pop_front();
      vectors++;
      if (e.cyc < cyc) begin
        fails++;
        $error("FAIL %s missed at cyc %0d want cyc %0d",
               t, cyc, e.cyc);
      end else begin
        assert ({mode, mode_changed, pulses} ===
                {e.m, e.c, e.p})
        else begin
          fails++;
          $error("FAIL %s got mode=%0d chg=%0b pulses=%0d want mode=%0d chg=%0b pulses=%0d",
                 t, mode, mode_changed, pulses, e.m, e.c, e.p);
        end
      end
    end
    if (done) begin
      while (q.size() > 0) begin
        string t;
        void'(q.pop_front());
        t = tq.pop_front();
        vectors++;
        fails++;
        $error("FAIL %s never checked", t);
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, fails);
      $finish;
    end
  end

  task automatic want(input string t, input int dc,
                      input logic [1:0] m, input logic c,
                      input int dp);
    exp_t e;
    e.cyc = cyc + dc;
    e.m   = m;
    e.c   = c;
    e.p   = base + dp;
    q.push_back(e);
    tq.push_back(t);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hit(input bit nx, input bit pv,
                     input logic [1:0] m, input logic c,
                     input string t);
    base = pulses;
    btn_next = nx;
    btn_prev = pv;
    tick(10);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(12);
    want(t, 0, m, 1'b0, c ? 1 : 0);
    tick(1);
  endtask

  initial begin
    want("rst_state", 1, 2'd0, 1'b0, 0);
    #25 rst = 1'b1;
    tick(1);

    base = pulses;
    for (int i = 1; i <= 10; i++)
      want("t1_idle", i * 10, 2'd0, 1'b0, 0);
    tick(101);

    base = pulses;
    want("t2_e6", 6, 2'd0, 1'b0, 0);
    want("t2_e7", 7, 2'd1, 1'b1, 1);
    want("t2_e8", 8, 2'd1, 1'b0, 1);
    btn_next = 1'b1;
    tick(10);
    btn_next = 1'b0;
    want("t2_rel", 20, 2'd1, 1'b0, 1);
    tick(21);

    base = pulses;
    #5 rst = 1'b0;
    want("mid_rst", 0, 2'd0, 1'b0, 0);
    tick(1);
    rst = 1'b1;
    tick(2);

    base = pulses;
    btn_next = 1'b1;
    tick(3);
    btn_next = 1'b0;
    tick(12);
    want("t3_glitch", 0, 2'd0, 1'b0, 0);
    tick(1);
    for (int i = 0; i < 2; i++) begin
      btn_next = 1'b1;
      tick(1);
      btn_next = 1'b0;
      tick(1);
    end
    tick(12);
    want("t3_toggle", 0, 2'd0, 1'b0, 0);
    tick(1);

    hit(1'b0, 1'b1, 2'd3, 1'b1, "t4_prev_wrap");
    hit(1'b1, 1'b0, 2'd0, 1'b1, "t4_next_wrap");
    hit(1'b1, 1'b0, 2'd1, 1'b1, "t4_step1");
    hit(1'b1, 1'b0, 2'd2, 1'b1, "t4_step2");
    hit(1'b1, 1'b0, 2'd3, 1'b1, "t4_step3");
    hit(1'b1, 1'b0, 2'd0, 1'b1, "t4_step0");

    hit(1'b1, 1'b1, 2'd0, 1'b0, "t5_both");

    hit(1'b1, 1'b0, 2'd1, 1'b1, "t6_pre1");
    hit(1'b1, 1'b0, 2'd2, 1'b1, "t6_pre2");

    base = pulses;
    want("t6_e7",  7,  2'd3, 1'b1, 1);
    want("t6_e26", 26, 2'd3, 1'b0, 1);
    want("t6_e27", 27, 2'd0, 1'b1, 2);
    want("t6_e28", 28, 2'd0, 1'b0, 2);
    want("t6_e39", 39, 2'd0, 1'b0, 2);
    btn_next = 1'b1;
    tick(40);
    btn_next = 1'b0;
    want("t6_rel", 20, 2'd0, 1'b0, 2);
    tick(21);

    base = pulses;
    want("t6b_e7",  7,  2'd1, 1'b1, 1);
    want("t6b_e27", 27, 2'd0, 1'b1, 2);
    want("t6b_e28", 28, 2'd0, 1'b0, 2);
    want("t6b_rel", 60, 2'd0, 1'b0, 2);
    btn_next = 1'b1;
    tick(40);
    btn_next = 1'b0;
    tick(21);

    done = 1'b1;
    tick(2);
    $display("FAIL timeout: monitor did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mode_select.md
Name: mode_select

Overview:
- Input-side driver for the LED animation top. It produces the 2-bit `mode` bus that the animation engine consumes.
- Converts two raw push-buttons (next/prev) into a registered mode value: synchronize, debounce, edge-detect, then step the mode with wrap-around.
- A long press on next returns to mode 0 ("home").
- A one-cycle `mode_changed` strobe lets the animation restart its pattern cleanly.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a button level is accepted (20 ms at 50 MHz).
- LONG_PRESS_CYCLES, 50_000_000, cycles the debounced next button must stay high after its press edge to trigger home (1 s at 50 MHz).
- NUM_MODES, 4, number of animation modes; mode range is 0..NUM_MODES-1.
- MODE_W, 2, width of `mode`; requires NUM_MODES <= 2**MODE_W.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- btn_next  input  1  raw button, active-high, asynchronous to clk, bouncy
- btn_prev  input  1  raw button, active-high, asynchronous to clk, bouncy
- mode  output  MODE_W  current animation mode, registered
- mode_changed  output  1  one-cycle pulse in the cycle `mode` first shows a new value

Behaviour:
- Reset (rst=0, asynchronous): mode=0, mode_changed=0, synchronizer flops=0, debounced levels=0, all counters=0, FSMs in IDLE. Release is synchronous to clk through the normal flop path.
- Synchronizer: 2-flop chain per button. No logic on the first flop.
- Debounce, per button:
  - Counter increments while the synchronized level differs from the debounced level.
  - Counter clears to 0 on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is never seen downstream.
- Latency: a raw level held from the edge before cycle 0 gives a debounced flip at edge DEBOUNCE_CYCLES+2. `mode` and `mode_changed` update at edge DEBOUNCE_CYCLES+3.
- Press event: rising edge of a debounced level (registered previous value), 1 cycle wide.
- Mode update, evaluated each cycle, priority top-down:
  1. Long-press event: mode <= 0.
  2. Next and prev press events in the same cycle: no change (ignored).
  3. Next press: mode <= (mode == NUM_MODES-1) ? 0 : mode+1.
  4. Prev press: mode <= (mode == 0) ? NUM_MODES-1 : mode-1.
- Next-button long-press FSM:
  - IDLE -> HOLD on a next press event; clear the hold counter.
  - HOLD -> IDLE when the debounced next goes low.
  - HOLD -> DONE when the hold counter reaches LONG_PRESS_CYCLES-1; emit the long-press event once.
  - DONE -> IDLE when the debounced next goes low. No repeat while held.
  - The hold counter saturates, never wraps.
- Net effect of a long press: the press edge steps mode +1, and later the long press forces 0.
- mode_changed = 1 only in the cycle after an update where the new value != the old value. A long press while already at mode 0 gives no pulse.
- Reset mid-operation: outputs return to reset values immediately. A button still held after release is seen as a fresh press after the normal latency.
- A prev long press has no special function.

Decomposition:
- Package `mode_pkg`: NUM_MODES, MODE_W, named mode constants (MODE_0..MODE_3), and the long-press FSM state encoding (IDLE, HOLD, DONE).
- Sub-module `btn_debounce` (synchronizer + debounce counter + rise-pulse output, parameter DEBOUNCE_CYCLES). Instantiated twice.
- Mode register and long-press FSM stay in `mode_select`.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, a 20 ns clock, and rst low 25 ns then high.
1. Reset only, buttons low for 100 cycles -> mode=0 and mode_changed=0 throughout; rst asserted mid-cycle drives mode to 0 without waiting for clk.
2. btn_next high for 10 cycles from mode 0 -> mode=1 at edge 7 (DEBOUNCE_CYCLES+3), mode_changed high for exactly 1 cycle, no further change on release.
3. btn_next glitch high for 3 cycles, and separately a 1-0-1-0 toggle over 4 cycles -> mode unchanged, no pulse.
4. Wrap: prev press from mode 0 -> 3; next press from 3 -> 0; four next presses from 0 -> 1, 2, 3, 0 with 4 pulses.
5. btn_next and btn_prev rising in the same cycle, held 10 cycles -> mode unchanged, no pulse.
6. From mode 2, hold btn_next 40 cycles -> mode 3 at edge 7, then mode 0 twenty cycles after the press event; exactly 2 pulses total; release produces nothing; repeating from mode 0 while mode steps to 1 then 0 gives 2 pulses.
